sata_xcvr_rst_supervisor: RTL and testbench
===========================================

# sata_xcvr_rst_supervisor

Link-side supervisor for the transceiver reset controller in the SATA PHY. It issues the controller's `reset`, waits for `tx_ready` and `rx_ready` with a timeout, and qualifies a stable link before raising `link_ready` to the SATA link layer. On timeout, loss of readiness, or an explicit request from the link layer, it re-runs the reset sequence. It also counts failed attempts for debug.

## Interface
Parameters:
- `RST_PULSE`, 8: cycles `xcvr_reset` is held per reset entry; must be at least 1.
- `READY_TIMEOUT`, 100000: cycles allowed from leaving reset hold until both readies are high; must be at least 2.
- `STABLE_CYCLES`, 1024: consecutive cycles both readies must stay high before `link_ready`; must be at least 1.
- `RETRY_WIDTH`, 8: width of the saturating retry counter.

Ports:
- `clock`  in  1  system clock; all logic is in this domain.
- `reset`  in  1  synchronous, active-high.
- `rst_req`  in  1  single-cycle request from the link layer to re-initialise the transceiver.
- `tx_ready`  in  1  TX ready from the reset controller; synchronous to `clock`.
- `rx_ready`  in  1  RX ready from the reset controller; synchronous to `clock`.
- `xcvr_reset`  out  1  drives the reset controller's `reset` input.
- `link_ready`  out  1  transceiver is up and stable.
- `timeout_evt`  out  1  one-cycle pulse when a ready timeout fires.
- `loss_evt`  out  1  one-cycle pulse when readiness is lost in UP.
- `retry_cnt`  out  RETRY_WIDTH  count of timeouts plus losses; saturates.

## Operation
- The state machine has five states: HOLD, WAIT_TX, WAIT_RX, STABLE, UP.
- While `reset` is high:
  - state = HOLD and all counters are 0.
  - `xcvr_reset`=1; `link_ready`, `timeout_evt` and `loss_evt` are 0; `retry_cnt` is 0.
- HOLD:
  - `xcvr_reset`=1 and the hold counter increments each cycle.
  - When hold count = RST_PULSE-1, go to WAIT_TX and clear the timer.
- WAIT_TX:
  - The timer increments each cycle.
  - `tx_ready`=1 → go to WAIT_RX; the timer is not cleared.
- WAIT_RX:
  - The timer continues.
  - `tx_ready`=0 → go to HOLD and increment retry (counts as a loss, but `loss_evt` is not pulsed).
  - Otherwise `rx_ready`=1 → go to STABLE and clear the stable counter.
- Timeout (WAIT_TX and WAIT_RX only):
  - Fires when timer = READY_TIMEOUT-1 and no forward transition is taken that cycle.
  - Effect: go to HOLD, pulse `timeout_evt`, increment retry.
- STABLE:
  - If both readies are high, the stable counter increments.
  - When the count reaches STABLE_CYCLES-1, go to UP.
  - Either ready low → go to WAIT_TX with the timer cleared; no retry increment and no reset.
- UP:
  - `link_ready`=1.
  - Either ready low → go to HOLD, pulse `loss_evt`, increment retry.
- Priority, highest first:
  1. `reset`
  2. `rst_req` (any state → HOLD, hold counter cleared, no retry increment, no event pulses)
  3. forward progress (ready beats timeout in the same cycle)
  4. timeout / loss
- `rst_req` while already in HOLD restarts the hold count.
- `retry_cnt` saturates at 2^RETRY_WIDTH-1. Only `reset` clears it.
- Counter widths are sized by $clog2 of the respective parameter. No counter wraps: every counter is cleared on state entry and bounded by its compare.

## Timing
- All outputs are registered and decoded from the state register, so there is no combinational input-to-output path.
- `xcvr_reset` is high for exactly RST_PULSE cycles per HOLD entry. The entry cycle counts as the first.
  - After `reset` falls, `xcvr_reset` stays high for RST_PULSE more cycles.
- Input sampled at edge N causes the state change at edge N+1, and the output reflects it in the cycle after edge N+1.
- Fastest bring-up: `link_ready` rises RST_PULSE + 2 + STABLE_CYCLES cycles after HOLD entry, with both readies already high.
- A timeout produces HOLD re-entry exactly READY_TIMEOUT cycles after WAIT_TX entry.
- `timeout_evt` and `loss_evt` are high for exactly one cycle, coincident with the first HOLD cycle.
- `link_ready` falls in the same cycle `xcvr_reset` rises after a loss.

## Test plan
Use RST_PULSE=8, READY_TIMEOUT=100, STABLE_CYCLES=16, RETRY_WIDTH=4.
1. Release `reset`; `tx_ready` rises 20 cycles after `xcvr_reset` falls and `rx_ready` 10 cycles later, both held → `xcvr_reset` high 8 cycles, `link_ready` rises after 16 stable cycles, `retry_cnt`=0.
2. Keep `rx_ready`=0 → `timeout_evt` every 108 cycles; `retry_cnt` counts to 15 and stays at 15; `link_ready` never rises.
3. In UP, drop `rx_ready` for 1 cycle → `loss_evt` pulse, `link_ready`=0, 8-cycle `xcvr_reset`, `retry_cnt`=1, then re-qualification.
4. In STABLE, glitch `tx_ready` low at stable count 10 → return to WAIT_TX, no `xcvr_reset`, `retry_cnt` unchanged, `link_ready` only after a fresh 16 stable cycles.
5. `rst_req` in UP, and again in HOLD cycle 5 → HOLD restarts, `xcvr_reset` stays high 8 cycles from the second request, no events, `retry_cnt` unchanged.
6. `tx_ready` rises in the same cycle the timer reaches 99 → go to WAIT_RX, no `timeout_evt`; assert `reset` in WAIT_RX → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/sata_xcvr_rst_supervisor.sv
// sata_xcvr_rst_supervisor
// Link-side supervisor for the SATA PHY transceiver reset controller.
// Drives the controller reset and waits for TX/RX ready with a timeout.
// Raises link_ready only after both readies have stayed high for a
// qualification window. Retries on timeout, on loss of readiness, or on
// a request from the link layer, and keeps a saturating count of failed
// attempts for debug.
module sata_xcvr_rst_supervisor #(
    parameter int RST_PULSE     = 8,
    parameter int READY_TIMEOUT = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int RETRY_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rst_req,
    input  logic                   tx_ready,
    input  logic                   rx_ready,
    output logic                   xcvr_reset,
    output logic                   link_ready,
    output logic                   timeout_evt,
    output logic                   loss_evt,
    output logic [RETRY_WIDTH-1:0] retry_cnt
);

    // Counter widths. A parameter of 1 would give a zero-width counter,
    // so such counters are kept one bit wide.
    localparam int HOLD_W   = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam int TIMER_W  = $clog2(READY_TIMEOUT);
    localparam int STABLE_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RST_PULSE - 1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(READY_TIMEOUT - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        WAIT_TX = 3'd1,
        WAIT_RX = 3'd2,
        STABLE  = 3'd3,
        UP      = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nxt;
    logic [TIMER_W-1:0]  timer;
    logic [TIMER_W-1:0]  timer_nxt;
    logic [STABLE_W-1:0] stable_cnt;
    logic [STABLE_W-1:0] stable_nxt;

    logic retry_inc;
    logic timeout_nxt;
    logic loss_nxt;

    logic req_q;
    logic tx_q;
    logic rx_q;

    logic timer_last;
    logic both_ready;
    logic [TIMER_W-1:0] timer_step;

    // The timer stops at its last value instead of wrapping; from there
    // the only ways out are a forward transition or the timeout itself.
    assign timer_last = (timer == TIMER_LAST);
    assign timer_step = timer_last ? timer : timer + TIMER_W'(1);
    assign both_ready = tx_q & rx_q;

    // Outputs are decoded straight from registers, never from inputs.
    assign xcvr_reset = (state == HOLD);
    assign link_ready = (state == UP);

    // Register the inputs once so every decision is taken on a registered copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_q <= 1'b0;
            tx_q  <= 1'b0;
            rx_q  <= 1'b0;
        end else begin
            req_q <= rst_req;
            tx_q  <= tx_ready;
            rx_q  <= rx_ready;
        end
    end

    // Next-state and counter decode; a link-layer request overrides all progress.
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        timer_nxt   = timer;
        stable_nxt  = stable_cnt;
        retry_inc   = 1'b0;
        timeout_nxt = 1'b0;
        loss_nxt    = 1'b0;

        if (req_q) begin
            state_nxt = HOLD;
            hold_nxt  = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = WAIT_TX;
                        timer_nxt = '0;
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end

                WAIT_TX: begin
                    timer_nxt = timer_step;
                    if (tx_q) begin
                        state_nxt = WAIT_RX;
                    end else if (timer_last) begin
                        state_nxt   = HOLD;
                        hold_nxt    = '0;
                        timeout_nxt = 1'b1;
                        retry_inc   = 1'b1;
                    end
                end

                WAIT_RX: begin
                    timer_nxt = timer_step;
                    if (!tx_q) begin
                        state_nxt = HOLD;
                        hold_nxt  = '0;
                        retry_inc = 1'b1;
                    end else if (rx_q) begin
                        state_nxt  = STABLE;
                        stable_nxt = '0;
                    end else if (timer_last) begin
                        state_nxt   = HOLD;
                        hold_nxt    = '0;
                        timeout_nxt = 1'b1;
                        retry_inc   = 1'b1;
                    end
                end

                STABLE: begin
                    if (!both_ready) begin
                        state_nxt = WAIT_TX;
                        timer_nxt = '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state_nxt = UP;
                    end else begin
                        stable_nxt = stable_cnt + STABLE_W'(1);
                    end
                end

                UP: begin
                    if (!both_ready) begin
                        state_nxt = HOLD;
                        hold_nxt  = '0;
                        loss_nxt  = 1'b1;
                        retry_inc = 1'b1;
                    end
                end

                default: begin
                    state_nxt = HOLD;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

    // State, counters and event pulses; events line up with the first HOLD cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            timer       <= '0;
            stable_cnt  <= '0;
            timeout_evt <= 1'b0;
            loss_evt    <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            timer       <= timer_nxt;
            stable_cnt  <= stable_nxt;
            timeout_evt <= timeout_nxt;
            loss_evt    <= loss_nxt;
        end
    end

    // Saturating retry counter; only the system reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            retry_cnt <= '0;
        end else if (retry_inc && (retry_cnt != {RETRY_WIDTH{1'b1}})) begin
            retry_cnt <= retry_cnt + RETRY_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_sata_xcvr_rst_supervisor.sv
// Self-checking bench for sata_xcvr_rst_supervisor.
// A table of stimulus/expectation records covers the first bring-up, and
// hand-written sequences cover loss, STABLE glitch, rst_req restart,
// timeout racing with tx_ready, and retry saturation.
module tb_sata_xcvr_rst_supervisor;

    localparam int RW = 4;

    logic          clock;
    logic          reset;
    logic          rst_req;
    logic          tx_ready;
    logic          rx_ready;
    logic          xcvr_reset;
    logic          link_ready;
    logic          timeout_evt;
    logic          loss_evt;
    logic [RW-1:0] retry_cnt;

    int checks;
    int fails;

    typedef struct {
        logic          rst;
        logic          req;
        logic          tx;
        logic          rx;
        int            cycles;
        logic          exp_x;
        logic          exp_l;
        logic          exp_te;
        logic          exp_le;
        logic [RW-1:0] exp_retry;
        string         name;
    } vec_t;

    vec_t vecs[8];

    sata_xcvr_rst_supervisor #(
        .RST_PULSE    (8),
        .READY_TIMEOUT(100),
        .STABLE_CYCLES(16),
        .RETRY_WIDTH  (RW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rst_req    (rst_req),
        .tx_ready   (tx_ready),
        .rx_ready   (rx_ready),
        .xcvr_reset (xcvr_reset),
        .link_ready (link_ready),
        .timeout_evt(timeout_evt),
        .loss_evt   (loss_evt),
        .retry_cnt  (retry_cnt)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic rst, input logic req,
                                 input logic tx, input logic rx);
        reset    = rst;
        rst_req  = req;
        tx_ready = tx;
        rx_ready = rx;
    endtask

    task automatic checkBit(input string name, input string field,
                            input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s.%s: got %b, expected %b", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic ex, input logic el,
                               input logic ete, input logic ele,
                               input logic [RW-1:0] er);
        checkBit(name, "xcvr_reset", xcvr_reset, ex);
        checkBit(name, "link_ready", link_ready, el);
        checkBit(name, "timeout_evt", timeout_evt, ete);
        checkBit(name, "loss_evt", loss_evt, ele);
        checks++;
        if (retry_cnt !== er) begin
            fails++;
            $display("[TB] FAIL %s.retry_cnt: got %0d, expected %0d", name, retry_cnt, er);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;

        // Bring-up vectors: inputs, cycles to run, outputs expected afterwards.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "in_reset"};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0,  7, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "hold_last"};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "hold_release"};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 19, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "wait_tx"};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "wait_rx"};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 17, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "stable_last"};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "link_up"};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 20, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "link_held"};

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].req, vecs[v].tx, vecs[v].rx);
            ticks(vecs[v].cycles);
            checkOutput(vecs[v].name, vecs[v].exp_x, vecs[v].exp_l,
                        vecs[v].exp_te, vecs[v].exp_le, vecs[v].exp_retry);
        end

        // Loss in UP: one-cycle rx_ready drop, then full re-qualification.
        rx_ready = 1'b0;
        tick();
        checkOutput("loss_latency", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        rx_ready = 1'b1;
        tick();
        checkOutput("loss_hold_entry", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        tick();
        checkOutput("loss_pulse_end", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        ticks(6);
        checkOutput("loss_hold_last", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        tick();
        checkOutput("loss_hold_release", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        ticks(11);

        // Glitch tx_ready so the FSM sees it low at stable count 10.
        tx_ready = 1'b0;
        tick();
        tx_ready = 1'b1;
        tick();
        checkOutput("glitch_back_to_wait", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        for (int i = 0; i < 17; i++) begin
            tick();
            checkOutput("glitch_requalify", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        end
        tick();
        checkOutput("glitch_link_up", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);

        // rst_req in UP, then again at hold count 5 to restart the hold.
        rst_req = 1'b1;
        tick();
        checkOutput("req_latency", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        rst_req = 1'b0;
        tick();
        checkOutput("req_hold_entry", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        ticks(4);
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("req_hold_restart", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        end
        tick();
        checkOutput("req_hold_release", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);

        // tx_ready arrives just as the timer reaches its last value.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        checkOutput("reset_clears_retry", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        ticks(106);
        tx_ready = 1'b1;
        tick();
        checkOutput("race_timer_last", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("race_ready_wins", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b1;
        tick();
        checkOutput("reset_in_wait_rx", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // rx_ready never rises: repeated timeouts, retry saturating at 15.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        ticks(2);
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            ticks(107);
            checkOutput("timeout_not_early", 1'b0, 1'b0, 1'b0, 1'b0,
                        RW'((k - 1 > 15) ? 15 : k - 1));
            tick();
            checkOutput("timeout_fire", 1'b1, 1'b0, 1'b1, 1'b0,
                        RW'((k > 15) ? 15 : k));
        end
        tick();
        checkOutput("timeout_pulse_end", 1'b1, 1'b0, 1'b0, 1'b0, 4'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
